mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single-port unified instruction/data memory of the pipelined core. It shares the memory between the fetch stage and the MEM stage and gives data accesses priority. A starvation counter guarantees the fetch stage a slot after a bounded run of data accesses. Read responses are returned registered, one cycle after grant, to the requester that owned the slot. It replaces the ad-hoc `Using_Mem` mux in the datapath and produces the fetch stall signal.

## Interface
- `ADDR_W`, 8: memory address width.
- `DATA_BASE`, 88: byte offset added to every data address; the data region starts here.
- `STARVE_MAX`, 4: maximum number of consecutive data grants while a fetch is pending.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `if_req` input 1: fetch request. Held, with `if_addr` stable, until `if_gnt`.
- `if_addr` input 32: fetch byte address (PC).
- `if_gnt` output 1: fetch owns the memory this cycle.
- `if_rvalid` output 1: `if_rdata` is valid; pulses for one cycle.
- `if_rdata` output 32: fetched instruction.
- `d_req` input 1: data request. Held, with all `d_*` inputs stable, until `d_gnt`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_funct3` input 3: access size and sign (RISC-V load/store funct3).
- `d_addr` input 32: data byte address (ALU result).
- `d_wdata` input 32: store data.
- `d_gnt` output 1: data owns the memory this cycle.
- `d_rvalid` output 1: `d_rdata` is valid; pulses for one cycle, loads only.
- `d_rdata` output 32: load result.
- `fetch_stall` output 1: `if_req & ~if_gnt`. Drives PC hold and NOP injection.
- `mem_read`, `mem_write` output 1 each: memory strobes.
- `mem_funct3` output 3: size to memory.
- `mem_addr` output `ADDR_W`: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_rdata` input 32: memory combinational read data.

## Operation
- Grant is combinational from the request inputs and the starvation counter. At most one grant is active per cycle.
- Priority:
  - Only one request active: that requester is granted.
  - Both active: data is granted unless `starve_cnt == STARVE_MAX`, in which case fetch is granted.
- `starve_cnt`, width `$clog2(STARVE_MAX+1)`:
  - Increments, saturating at `STARVE_MAX`, on each cycle where `d_gnt & if_req`.
  - Clears on any `if_gnt`.
  - Otherwise it holds.
- Fetch grant drives `mem_read=1`, `mem_write=0`, `mem_funct3=3'b010`, `mem_addr=if_addr[ADDR_W-1:0]`.
- Data grant drives `mem_read=~d_we`, `mem_write=d_we`, `mem_funct3=d_funct3`, `mem_addr=d_addr[ADDR_W-1:0]+DATA_BASE`. The address sum wraps modulo 2^ADDR_W.
- With no grant, all `mem_*` outputs are 0.
- Owner FSM, registered, states `OWN_NONE`, `OWN_IF`, `OWN_DLOAD`. Next state:
  - `OWN_IF` if `if_gnt`.
  - `OWN_DLOAD` if `d_gnt & ~d_we`.
  - `OWN_NONE` otherwise. This covers stores and idle cycles.
- Response capture:
  - Granted read cycle: `mem_rdata` is captured into `if_rdata` or `d_rdata`, according to the grant.
  - `if_rvalid = (state==OWN_IF)`, `d_rvalid = (state==OWN_DLOAD)`.
  - Each rdata register holds its value until that requester's next read grant.
- Stores produce no rvalid. The write commits at the clock edge of the grant cycle.
- Reset values: state `OWN_NONE`, `starve_cnt` 0, `if_rdata`/`d_rdata` 0, both rvalid 0. The grant and mem outputs are 0 while `rst` is high.

## Timing
- Grant latency is 0 cycles from request when the request wins arbitration.
- Read latency: rvalid and rdata are asserted in cycle N+1 for a grant in cycle N.
- Back-to-back grants to either requester are allowed every cycle. Throughput is 1 access/cycle.
- Worst-case fetch wait under continuous data requests is `STARVE_MAX` cycles. The grant comes in cycle `STARVE_MAX+1`.
- Simultaneous events:
  - A new grant in the same cycle as a pending rvalid is legal. The rvalid refers to the previous cycle.
  - `d_req` dropped without a grant is ignored; nothing is latched.
- Reset asserted mid-operation clears the FSM immediately (asynchronously). A pending rvalid is lost and must not appear after reset is released.

## Structure
- Shared package `core_pkg`:
  - owner-state enum (`OWN_NONE`, `OWN_IF`, `OWN_DLOAD`).
  - `FUNCT3_WORD = 3'b010`.
  - `DATA_BASE` default constant.
- Sub-module: `starve_counter`, a saturating counter with inc/clr/full outputs. All other logic stays flat in `mem_port_arbiter`.

## Test plan
- Fetch only:
  - Stimulus: `if_req=1`, `if_addr=0x10`, `mem_rdata=0x00500093`.
  - Required: `if_gnt=1` and `mem_addr=0x10` the same cycle; next cycle `if_rvalid=1`, `if_rdata=0x00500093`, `fetch_stall=0`.
- Load wins conflict:
  - Stimulus: `if_req=1`, `d_req=1`, `d_we=0`, `d_addr=0x4`, `d_funct3=3'b000`.
  - Required: `d_gnt=1`, `mem_addr=92`, `fetch_stall=1`; next cycle `d_rvalid=1`, `if_rvalid=0`.
- Starvation bound:
  - Stimulus: `if_req` and `d_req` held high continuously, `STARVE_MAX=4`.
  - Required: 4 `d_gnt` cycles, then `if_gnt` in cycle 5 with counter cleared, then data resumes.
- Store:
  - Stimulus: `d_we=1`, `d_addr=0xF0`, `d_wdata=0xDEADBEEF`, `d_funct3=3'b010`.
  - Required: `mem_write=1`, `mem_addr=0x48` (wrap of 240+88); no `d_rvalid` next cycle.
- Reset mid-read:
  - Stimulus: fetch granted in cycle N, `rst` pulsed before edge N+1.
  - Required: `if_rvalid=0`, `if_rdata=0`, `starve_cnt=0` after reset.
- Idle and hold:
  - Stimulus: no requests for 3 cycles after a load returned `0x1234`.
  - Required: all `mem_*` 0, rvalid 0, `d_rdata` stays `0x1234`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: memory-port owner states, funct3 encodings and
// the default placement of the data region in the unified memory.
package core_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_DLOAD = 2'd2
    } owner_e;

    localparam logic [2:0] FUNCT3_WORD       = 3'b010;
    localparam int         DATA_BASE_DEFAULT = 88;

    // Width of a counter that must reach max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// Clear wins over increment; full flags the saturation value.
module starve_counter
    import core_pkg::*;
#(
    parameter int MAX_VAL = 4,
    parameter int W       = cnt_width(MAX_VAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         full
);

    assign full = (cnt == W'(MAX_VAL));

    // Count up to MAX_VAL and stick there until the fetch side gets a slot.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !full) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port unified memory shared by fetch and MEM stage.
// Data wins conflicts until the starvation counter saturates; read data is
// registered and returned one cycle after the grant to the slot's owner.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_BASE  = DATA_BASE_DEFAULT,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    // pipeline control
    output logic              fetch_stall,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int                CNT_W    = cnt_width(STARVE_MAX);
    localparam logic [ADDR_W-1:0] DATA_OFS = ADDR_W'(DATA_BASE);

    logic             starve_full;
    logic [CNT_W-1:0] starve_cnt;
    owner_e           state;

    // Upper address bits are outside the memory and intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    // Data has priority unless the fetch side has waited STARVE_MAX grants;
    // both grants are forced low while reset is asserted.
    assign d_gnt       = ~rst & d_req & ~(if_req & starve_full);
    assign if_gnt      = ~rst & if_req & (~d_req | starve_full);
    assign fetch_stall = if_req & ~if_gnt;

    starve_counter #(
        .MAX_VAL (STARVE_MAX),
        .W       (CNT_W)
    ) u_starve (
        .clk  (clk),
        .rst  (rst),
        .inc  (d_gnt & if_req),
        .clr  (if_gnt),
        .cnt  (starve_cnt),
        .full (starve_full)
    );

    // Steer the granted requester onto the memory strobes; idle drives zeros.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = 3'b000;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (if_gnt) begin
            mem_read   = 1'b1;
            mem_funct3 = FUNCT3_WORD;
            mem_addr   = if_addr[ADDR_W-1:0];
        end else if (d_gnt) begin
            mem_read   = ~d_we;
            mem_write  = d_we;
            mem_funct3 = d_funct3;
            mem_addr   = d_addr[ADDR_W-1:0] + DATA_OFS;
            mem_wdata  = d_wdata;
        end
    end

    // Owner FSM plus response capture: remember who owns the read in flight
    // and latch memory data into that requester's register at the grant edge.
    // NOTE: the rdata registers are reset too, so a read lost to reset never
    // leaves stale data visible afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OWN_NONE;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if (if_gnt) begin
                state    <= OWN_IF;
                if_rdata <= mem_rdata;
            end else if (d_gnt && !d_we) begin
                state    <= OWN_DLOAD;
                d_rdata  <= mem_rdata;
            end else begin
                state    <= OWN_NONE;
            end
        end
    end

    assign if_rvalid = (state == OWN_IF);
    assign d_rvalid  = (state == OWN_DLOAD);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each cycle's expected grant and memory
// strobes are checked mid-cycle, and the expected response is queued and
// compared after the following clock edge.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        fetch_stall;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(
        .ADDR_W     (8),
        .DATA_BASE  (88),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_funct3    (d_funct3),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .fetch_stall (fetch_stall),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_funct3  (mem_funct3),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // owner: 0 none, 1 fetch read, 2 data load
    typedef struct {
        int          owner;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_cnt = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_funct3  = 3'b000;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
    endtask

    // Mid-cycle check of grants and memory strobes for the current inputs;
    // own is the expected owner (0 none, 1 fetch, 2 data).
    task automatic step(input string tag, input int own, input logic [7:0] e_addr,
                        output logic obs_if_gnt);
        logic [2:0]  e_f3;
        logic [31:0] e_wd;
        logic        e_rd, e_wr;
        resp_t       r;
        e_rd = 1'b0; e_wr = 1'b0; e_f3 = 3'b000; e_wd = '0;
        if (own == 1) begin
            e_rd = 1'b1; e_f3 = 3'b010;
        end else if (own == 2) begin
            e_rd = ~d_we; e_wr = d_we; e_f3 = d_funct3; e_wd = d_wdata;
        end
        @(negedge clk);
        obs_if_gnt = if_gnt;
        check({tag, ".if_gnt"},      32'(if_gnt),      32'(own == 1));
        check({tag, ".d_gnt"},       32'(d_gnt),       32'(own == 2));
        check({tag, ".fetch_stall"}, 32'(fetch_stall), 32'(if_req && own != 1));
        check({tag, ".mem_read"},    32'(mem_read),    32'(e_rd));
        check({tag, ".mem_write"},   32'(mem_write),   32'(e_wr));
        check({tag, ".mem_funct3"},  32'(mem_funct3),  32'(e_f3));
        check({tag, ".mem_addr"},    32'(mem_addr),    32'((own == 0) ? 8'h00 : e_addr));
        check({tag, ".mem_wdata"},   mem_wdata,        e_wd);
        r.owner = (own == 2 && d_we) ? 0 : own;
        r.data  = mem_rdata;
        sb.push_back(r);
        if (own == 1)
            model_cnt = 0;
        else if (own == 2 && if_req && model_cnt < STARVE_MAX)
            model_cnt++;
    endtask

    // Advance past the clock edge and compare the queued response.
    task automatic tick(input string tag);
        resp_t r;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            r.owner = 0;
            r.data  = '0;
        end else begin
            r = sb.pop_front();
        end
        if (r.owner == 1) exp_if_rdata = r.data;
        if (r.owner == 2) exp_d_rdata  = r.data;
        check({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(r.owner == 1));
        check({tag, ".d_rvalid"},  32'(d_rvalid),  32'(r.owner == 2));
        check({tag, ".if_rdata"},  if_rdata,       exp_if_rdata);
        check({tag, ".d_rdata"},   d_rdata,        exp_d_rdata);
    endtask

    task automatic cyc(input string tag, input int own, input logic [7:0] e_addr);
        logic g;
        step(tag, own, e_addr, g);
        tick(tag);
    endtask

    // Both requesters held high for n cycles; the bench's own counter model
    // decides who should win. Returns the cycle index of the first fetch grant.
    task automatic run_conflict(input string tag, input int n, output int first_if);
        int   own;
        logic g;
        first_if = -1;
        if_req = 1'b1; if_addr = 32'h40;
        d_req  = 1'b1; d_we = 1'b0; d_funct3 = 3'b010;
        for (int i = 0; i < n; i++) begin
            d_addr    = 32'(i * 4);
            mem_rdata = 32'hC000_0000 + 32'(i);
            own = (model_cnt == STARVE_MAX) ? 1 : 2;
            step(tag, own, (own == 1) ? 8'h40 : 8'(i * 4 + 88), g);
            if (g && first_if < 0) first_if = i;
            tick(tag);
        end
        idle_inputs();
    endtask

    initial begin
        int  first_if;
        logic g;

        // Reset state, with a fetch request present to show grants are held off.
        idle_inputs();
        rst    = 1'b1;
        if_req = 1'b1;
        @(negedge clk);
        check("reset.if_gnt",    32'(if_gnt),    32'd0);
        check("reset.mem_read",  32'(mem_read),  32'd0);
        check("reset.if_rvalid", 32'(if_rvalid), 32'd0);
        check("reset.d_rvalid",  32'(d_rvalid),  32'd0);
        check("reset.if_rdata",  if_rdata,       32'd0);
        check("reset.d_rdata",   d_rdata,        32'd0);
        if_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fetch only.
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h0050_0093;
        step("fetch", 1, 8'h10, g);
        tick("fetch");
        idle_inputs();
        step("fetch_after", 0, 8'h00, g);
        check("fetch_after.stall", 32'(fetch_stall), 32'd0);
        tick("fetch_after");

        // Load wins a conflict: address 4 + 88 = 92.
        if_req = 1'b1; if_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4; d_funct3 = 3'b000;
        mem_rdata = 32'h0000_00A5;
        cyc("load_conflict", 2, 8'd92);
        // Fetch alone afterwards clears the starvation count.
        d_req = 1'b0; mem_rdata = 32'h0000_0013;
        cyc("fetch_clear", 1, 8'h14);
        idle_inputs();

        // Starvation bound: 4 data grants, fetch in the 5th cycle, repeat.
        run_conflict("starve", 10, first_if);
        check("starve.first_if_cycle", 32'(first_if), 32'(STARVE_MAX));

        // Store wrapping the address: 0xF0 + 88 = 0x148 -> 0x48, no d_rvalid.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hF0; d_wdata = 32'hDEAD_BEEF;
        d_funct3 = 3'b010; mem_rdata = 32'h5555_5555;
        cyc("store", 2, 8'h48);
        idle_inputs();

        // Load returning 0x1234, then three idle cycles holding d_rdata.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_funct3 = 3'b010;
        mem_rdata = 32'h0000_1234;
        cyc("load_hold", 2, 8'd96);
        idle_inputs();
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) cyc("idle", 0, 8'h00);
        check("idle.d_rdata_held", d_rdata, 32'h0000_1234);

        // Reset mid-read: build a nonzero count, grant a fetch, reset before the edge.
        if_req = 1'b1; if_addr = 32'h24;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_funct3 = 3'b010;
        mem_rdata = 32'h1111_1111;
        cyc("pre_rst_load0", 2, 8'd88);
        cyc("pre_rst_load1", 2, 8'd88);
        d_req = 1'b0; mem_rdata = 32'h2222_2222;
        step("rst_fetch", 1, 8'h24, g);
        rst = 1'b1;
        #1;
        check("rst_mid.if_gnt",   32'(if_gnt),   32'd0);
        check("rst_mid.mem_read", 32'(mem_read), 32'd0);
        idle_inputs();
        #1;
        rst = 1'b0;
        sb.delete();
        model_cnt    = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        tick("after_rst");
        check("after_rst.starve_cnt", 32'(dut.starve_cnt), 32'd0);

        // A cleared counter must again allow the full run of data grants.
        run_conflict("starve_after_rst", 5, first_if);
        check("starve_after_rst.first_if_cycle", 32'(first_if), 32'(STARVE_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
